// File: rtl/mem_req_queue.sv
// In-order load/store request queue feeding the memory controller port.
// Stores wait for ROB commit; IO loads wait until they reach the ROB head.
module mem_req_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             roll_back,
    input  logic             push_en,
    input  logic             push_is_store,
    input  logic [1:0]       push_width,
    input  logic             push_signed,
    input  logic [31:0]      push_addr,
    input  logic [31:0]      push_data,
    input  logic [TAG_W-1:0] push_tag,
    output logic             full,
    input  logic             commit_en,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [TAG_W-1:0] rob_head_tag,
    output logic             lsb_rw,
    output logic [1:0]       lsb_d_type,
    output logic [31:0]      lsb_ain,
    output logic [31:0]      lsb_din,
    input  logic             lsb_dout_en,
    input  logic [31:0]      lsb_dout,
    input  logic             lsb_w_done,
    output logic             res_en,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      res_data
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_V = DEPTH[PW:0];
    localparam logic [PW-1:0] P1 = 1;
    localparam logic [PW:0]   C1 = 1;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, GAP} state_t;
    state_t state_q;

    logic [DEPTH-1:0] st_q, sgn_q, cmt_q;
    logic [1:0]       wid_q  [DEPTH];
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, cidx;
    logic [PW:0]   count_q, count_d, ccnt_q, ccnt_d;

    logic push_ok, commit_ok, pop, issue, head_io, head_ok;
    logic [31:0] ext;

    assign full      = (count_q == DEPTH_V);
    assign push_ok   = push_en && !full && !roll_back;
    assign cidx      = head_q + ccnt_q[PW-1:0];
    assign commit_ok = commit_en && (ccnt_q < count_q) && st_q[cidx]
                       && (tag_q[cidx] == commit_tag);
    assign head_io   = (addr_q[head_q][17:16] == 2'b11);
    assign head_ok   = st_q[head_q] ? cmt_q[head_q]
                       : (!head_io || tag_q[head_q] == rob_head_tag);
    assign issue     = (state_q == IDLE) && (count_q != '0)
                       && !roll_back && head_ok;
    assign pop       = (state_q == WAIT) && (st_q[head_q] ? lsb_w_done
                       : (lsb_dout_en && !roll_back));

    always_comb begin
        ext = lsb_dout;
        unique case (wid_q[head_q])
            2'b01: ext = sgn_q[head_q] ? {{24{lsb_dout[7]}}, lsb_dout[7:0]}
                                       : {24'b0, lsb_dout[7:0]};
            2'b10: ext = sgn_q[head_q] ? {{16{lsb_dout[15]}}, lsb_dout[15:0]}
                                       : {16'b0, lsb_dout[15:0]};
            default: ext = lsb_dout;
        endcase
    end

    // Commit lands before the flush so a same-cycle commit survives it.
    always_comb begin
        ccnt_d = ccnt_q;
        if (commit_ok) ccnt_d = ccnt_d + C1;
        if (pop && st_q[head_q]) ccnt_d = ccnt_d - C1;
        head_d = pop ? head_q + P1 : head_q;
        tail_d = push_ok ? tail_q + P1 : tail_q;
        count_d = count_q;
        if (push_ok) count_d = count_d + C1;
        if (pop) count_d = count_d - C1;
        if (roll_back) begin
            tail_d  = head_d + ccnt_d[PW-1:0];
            count_d = ccnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ccnt_q     <= '0;
            st_q       <= '0;
            sgn_q      <= '0;
            cmt_q      <= '0;
            lsb_rw     <= 1'b0;
            lsb_d_type <= 2'b00;
            lsb_ain    <= '0;
            lsb_din    <= '0;
            res_en     <= 1'b0;
            res_tag    <= '0;
            res_data   <= '0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ccnt_q  <= ccnt_d;
            res_en  <= 1'b0;
            if (push_ok) begin
                st_q[tail_q]   <= push_is_store;
                sgn_q[tail_q]  <= push_signed;
                cmt_q[tail_q]  <= 1'b0;
                wid_q[tail_q]  <= push_width;
                addr_q[tail_q] <= push_addr;
                data_q[tail_q] <= push_data;
                tag_q[tail_q]  <= push_tag;
            end
            if (commit_ok) cmt_q[cidx] <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        lsb_d_type <= wid_q[head_q];
                        lsb_rw     <= st_q[head_q];
                        lsb_ain    <= addr_q[head_q];
                        lsb_din    <= data_q[head_q];
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    lsb_d_type <= 2'b00;
                    if (st_q[head_q]) begin
                        if (lsb_w_done) begin
                            lsb_rw  <= 1'b0;
                            state_q <= GAP;
                        end
                    end else if (lsb_dout_en) begin
                        if (!roll_back) begin
                            res_en   <= 1'b1;
                            res_tag  <= tag_q[head_q];
                            res_data <= ext;
                        end
                        state_q <= GAP;
                    end else if (roll_back) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (lsb_dout_en) state_q <= IDLE;
                end
                GAP: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: issue handshake, commit gating,
// wrap-around ordering, roll_back flush and load drain.
module tb_mem_req_queue;
    logic        clk = 1'b0;
    logic        rst_in, rdy_in, roll_back;
    logic        push_en, push_is_store, push_signed;
    logic [1:0]  push_width;
    logic [31:0] push_addr, push_data;
    logic [3:0]  push_tag, commit_tag, rob_head_tag, res_tag;
    logic        full, commit_en;
    logic        lsb_rw, lsb_dout_en, lsb_w_done, res_en;
    logic [1:0]  lsb_d_type;
    logic [31:0] lsb_ain, lsb_din, lsb_dout, res_data;

    int total = 0;
    int bad   = 0;

    mem_req_queue #(.DEPTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
        .push_en(push_en), .push_is_store(push_is_store),
        .push_width(push_width), .push_signed(push_signed),
        .push_addr(push_addr), .push_data(push_data), .push_tag(push_tag),
        .full(full), .commit_en(commit_en), .commit_tag(commit_tag),
        .rob_head_tag(rob_head_tag), .lsb_rw(lsb_rw),
        .lsb_d_type(lsb_d_type), .lsb_ain(lsb_ain), .lsb_din(lsb_din),
        .lsb_dout_en(lsb_dout_en), .lsb_dout(lsb_dout),
        .lsb_w_done(lsb_w_done), .res_en(res_en), .res_tag(res_tag),
        .res_data(res_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tg, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    task automatic push(input logic st, input logic [1:0] w, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] t);
        push_en = 1'b1; push_is_store = st; push_width = w;
        push_signed = sg; push_addr = a; push_data = d; push_tag = t;
        step();
        push_en = 1'b0;
    endtask

    task automatic commit(input logic [3:0] t);
        commit_en = 1'b1; commit_tag = t;
        step();
        commit_en = 1'b0;
    endtask

    task automatic load_done(input logic [31:0] d);
        lsb_dout = d; lsb_dout_en = 1'b1;
        step();
        lsb_dout_en = 1'b0;
    endtask

    task automatic wait_issue(input string tg, input logic [1:0] ty,
                              input logic rw, input logic [31:0] a);
        int n = 0;
        while (lsb_d_type == 2'b00 && n < 20) begin
            step();
            n++;
        end
        chk({tg, "_type"}, 32'(lsb_d_type), 32'(ty));
        chk({tg, "_rw"}, 32'(lsb_rw), 32'(rw));
        chk({tg, "_ain"}, lsb_ain, a);
        step();
        chk({tg, "_pulse"}, 32'(lsb_d_type), 32'd0);
    endtask

    task automatic store_cycle(input string tg, input logic [31:0] a,
                               input logic [31:0] d);
        int n = 0;
        while (lsb_rw !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tg, "_rw"}, 32'(lsb_rw), 32'd1);
        chk({tg, "_ain"}, lsb_ain, a);
        chk({tg, "_din"}, lsb_din, d);
        lsb_w_done = 1'b1;
        step();
        lsb_w_done = 1'b0;
        chk({tg, "_done"}, 32'(lsb_rw), 32'd0);
    endtask

    task automatic quiet(input string tg, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (lsb_d_type != 2'b00 || res_en) seen = 1'b1;
        end
        chk(tg, 32'(seen), 32'd0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
        push_en = 1'b0; push_is_store = 1'b0; push_width = 2'b00;
        push_signed = 1'b0; push_addr = '0; push_data = '0; push_tag = '0;
        commit_en = 1'b0; commit_tag = '0; rob_head_tag = '0;
        lsb_dout_en = 1'b0; lsb_dout = '0; lsb_w_done = 1'b0;
        step();
        step();
        rst_in = 1'b0;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dtype", 32'(lsb_d_type), 32'd0);
        chk("rst_rw", 32'(lsb_rw), 32'd0);
        chk("rst_ain", lsb_ain, 32'd0);
        chk("rst_din", lsb_din, 32'd0);
        chk("rst_res_en", 32'(res_en), 32'd0);
        chk("rst_res_tag", 32'(res_tag), 32'd0);
        chk("rst_res_data", res_data, 32'd0);

        // signed byte load
        push(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 4'd1);
        wait_issue("lb", 2'b01, 1'b0, 32'h100);
        load_done(32'h0000_0080);
        chk("lb_res_en", 32'(res_en), 32'd1);
        chk("lb_res_tag", 32'(res_tag), 32'd1);
        chk("lb_res_data", res_data, 32'hFFFF_FF80);
        step();
        chk("lb_res_pulse", 32'(res_en), 32'd0);
        chk("lb_res_hold", res_data, 32'hFFFF_FF80);

        // unsigned byte load
        push(1'b0, 2'b01, 1'b0, 32'h104, 32'h0, 4'd2);
        wait_issue("lbu", 2'b01, 1'b0, 32'h104);
        load_done(32'h0000_0080);
        chk("lbu_res_tag", 32'(res_tag), 32'd2);
        chk("lbu_res_data", res_data, 32'h0000_0080);

        // store waits for commit
        push(1'b1, 2'b11, 1'b0, 32'h200, 32'hDEAD_BEEF, 4'd5);
        quiet("st_nocommit", 20);
        commit(4'd5);
        wait_issue("st", 2'b11, 1'b1, 32'h200);
        chk("st_din", lsb_din, 32'hDEAD_BEEF);
        step();
        step();
        chk("st_din_hold", lsb_din, 32'hDEAD_BEEF);
        chk("st_rw_hold", 32'(lsb_rw), 32'd1);
        lsb_w_done = 1'b1;
        step();
        lsb_w_done = 1'b0;
        chk("st_done_rw", 32'(lsb_rw), 32'd0);
        chk("st_done_res", 32'(res_en), 32'd0);

        // IO load held until it is the ROB head
        rob_head_tag = 4'd0;
        push(1'b0, 2'b11, 1'b0, 32'h0003_0000, 32'h0, 4'd3);
        quiet("io_hold", 10);
        rob_head_tag = 4'd3;
        wait_issue("io", 2'b11, 1'b0, 32'h0003_0000);
        load_done(32'h1234_5678);
        chk("io_res_tag", 32'(res_tag), 32'd3);
        chk("io_res_data", res_data, 32'h1234_5678);
        step();

        // fill across the pointer wrap, drop the ninth push
        for (int i = 0; i < 8; i++)
            push(1'b1, 2'b11, 1'b0, 32'h400 + 32'(4 * i), 32'(i), 4'(i));
        chk("fill_full", 32'(full), 32'd1);
        push(1'b0, 2'b11, 1'b0, 32'h800, 32'h0, 4'd8);
        chk("fill_drop_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) commit(4'(i));
        for (int i = 0; i < 8; i++)
            store_cycle($sformatf("fifo%0d", i),
                        32'h400 + 32'(4 * i), 32'(i));
        quiet("fill_dropped", 10);
        chk("fill_empty", 32'(full), 32'd0);

        // roll_back keeps committed store, flushes loads behind it
        push(1'b1, 2'b11, 1'b0, 32'h500, 32'hCAFE_0001, 4'd9);
        push(1'b0, 2'b11, 1'b0, 32'h600, 32'h0, 4'd10);
        push(1'b0, 2'b11, 1'b0, 32'h604, 32'h0, 4'd11);
        commit(4'd9);
        for (int n = 0; n < 20 && lsb_rw !== 1'b1; n++) step();
        chk("rb_st_rw", 32'(lsb_rw), 32'd1);
        roll_back = 1'b1;
        step();
        roll_back = 1'b0;
        chk("rb_st_ain", lsb_ain, 32'h500);
        chk("rb_st_din", lsb_din, 32'hCAFE_0001);
        lsb_w_done = 1'b1;
        step();
        lsb_w_done = 1'b0;
        chk("rb_st_done", 32'(lsb_rw), 32'd0);
        quiet("rb_flushed", 12);

        // load aborted in flight drains its replayed response
        push(1'b0, 2'b01, 1'b1, 32'h700, 32'h0, 4'd12);
        wait_issue("dr", 2'b01, 1'b0, 32'h700);
        roll_back = 1'b1;
        step();
        roll_back = 1'b0;
        push(1'b0, 2'b10, 1'b1, 32'h704, 32'h0, 4'd13);
        quiet("dr_noissue", 3);
        load_done(32'h0000_0055);
        chk("dr_discard", 32'(res_en), 32'd0);
        chk("dr_res_hold", res_data, 32'h1234_5678);
        wait_issue("rp", 2'b10, 1'b0, 32'h704);
        load_done(32'h0000_8001);
        chk("rp_res_en", 32'(res_en), 32'd1);
        chk("rp_res_tag", 32'(res_tag), 32'd13);
        chk("rp_res_data", res_data, 32'hFFFF_8001);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
